hc595_scan_driver: RTL and testbench

HC595_SCAN_DRIVER -- requirements
Module: hc595_scan_driver

---
 rtl/hc595_pkg.sv | 24 ++
 rtl/hex_to_seg.sv | 13 +
 rtl/hc595_scan_driver.sv | 203 ++++++++++++++++++++
 tb/tb_hc595_scan_driver.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/hc595_pkg.sv
// Shared types and constants for the 74HC595 scan driver.
package hc595_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT_LO,
      SHIFT_HI,
      LATCH
   } state_t;

   // Number of bits shifted per digit slot: {seg[7:0], sel[7:0]}.
   localparam int unsigned WORD_BITS = 16;

   // Unlit segment pattern in active-high form; polarity is applied afterwards.
   localparam logic [7:0] SEG_OFF = 8'h00;

   // Hex to 7-segment code, bit 6..0 = g..a, active-high, entry 0 rightmost.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble + decimal point to active-high segment code.
module hex_to_seg
   import hc595_pkg::*;
(
   input  logic [3:0] nib,
   input  logic       dp,
   output logic [7:0] seg
);

   // Table lookup with the decimal point in bit 7.
   always_comb seg = {dp, SEG_TABLE[nib]};

endmodule

// File: rtl/hc595_scan_driver.sv
// Multiplexed 7-segment scan driver feeding two cascaded 74HC595s.
// Optional leading-zero blanking: define HC595_LZ_BLANK_EN.
module hc595_scan_driver
   import hc595_pkg::*;
#(
   parameter int unsigned DIGITS         = 6,
   parameter int unsigned CLK_DIV        = 2,
   parameter int unsigned SCAN_CYC       = 50_000,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                  sys_clk,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   din,
   input  logic [DIGITS-1:0]     dp,
   input  logic                  upd,
   input  logic                  en,
   output logic                  ds,
   output logic                  sh_clk,
   output logic                  st_clk,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int unsigned DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned SW   = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
   localparam int unsigned XFER = 34 * CLK_DIV + 1;

   if (SCAN_CYC <= XFER) begin : g_bad_scan
      $error("hc595_scan_driver: SCAN_CYC must exceed 34*CLK_DIV+1");
   end
   if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
      $error("hc595_scan_driver: DIGITS must be 1..8");
   end
   if (CLK_DIV < 1) begin : g_bad_div
      $error("hc595_scan_driver: CLK_DIV must be at least 1");
   end

   state_t              state;
   logic [SW-1:0]       scan_cnt;
   logic                tick;
   logic [DW-1:0]       div_cnt;
   logic                div_last;
   logic [3:0]          bit_cnt;
   logic [WORD_BITS-1:0] shreg;
   logic [2:0]          idx;

   logic [4*DIGITS-1:0] pend_din, shadow_din, load_din;
   logic [DIGITS-1:0]   pend_dp, shadow_dp, load_dp;

   logic [3:0]          nib;
   logic                dp_bit;
   logic                blank;
   logic [7:0]          seg_code;
   logic [7:0]          seg_raw;
   logic [7:0]          seg;
   logic [7:0]          sel;
   logic [WORD_BITS-1:0] word;

   assign tick     = (scan_cnt == SW'(SCAN_CYC - 1));
   assign div_last = (div_cnt == DW'(CLK_DIV - 1));

   // Free-running slot timer.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n)    scan_cnt <= '0;
      else if (tick) scan_cnt <= '0;
      else           scan_cnt <= scan_cnt + 1'b1;
   end

   // Pending register captures every update strobe.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_din <= '0;
         pend_dp  <= '0;
      end else if (upd) begin
         pend_din <= din;
         pend_dp  <= dp;
      end
   end

   // Data source for the word: at digit 0 the frame takes pending (or a same-cycle
   // strobe), otherwise the shadow frozen at the start of the frame.
   always_comb begin
      if (idx == 3'd0) begin
         load_din = upd ? din : pend_din;
         load_dp  = upd ? dp  : pend_dp;
      end else begin
         load_din = shadow_din;
         load_dp  = shadow_dp;
      end
   end

   // Pick the nibble and decimal point of the current digit.
   always_comb begin
      nib    = '0;
      dp_bit = 1'b0;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (idx == 3'(k)) begin
            nib    = load_din[4*k +: 4];
            dp_bit = load_dp[k];
         end
      end
   end

`ifdef HC595_LZ_BLANK_EN
   // Blank a non-zero digit position whose nibble and all higher nibbles are zero.
   always_comb begin
      logic upper_zero;
      upper_zero = 1'b1;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (3'(k) >= idx && load_din[4*k +: 4] != 4'h0) upper_zero = 1'b0;
      end
      blank = (idx != 3'd0) && !dp_bit && upper_zero;
   end
`else
   // Every digit is shown, leading zeros included.
   always_comb blank = 1'b0;
`endif

   hex_to_seg u_hex_to_seg (
      .nib (nib),
      .dp  (dp_bit),
      .seg (seg_code)
   );

   // Assemble the shift word: segments with polarity applied, active-low digit select.
   always_comb begin
      seg_raw = (en && !blank) ? seg_code : SEG_OFF;
      seg     = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
      sel     = ~(8'h01 << idx);
      word    = {seg, sel};
   end

   // Transfer sequencer with registered pin outputs.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         idx        <= '0;
         ds         <= 1'b0;
         sh_clk     <= 1'b0;
         st_clk     <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         shadow_din <= '0;
         shadow_dp  <= '0;
      end else begin
         if (state == IDLE) div_cnt <= '0;
         else               div_cnt <= div_last ? '0 : div_cnt + 1'b1;
         case (state)
            IDLE: begin
               frame_done <= 1'b0;
               sh_clk     <= 1'b0;
               st_clk     <= 1'b0;
               if (tick) begin
                  state <= LOAD;
                  busy  <= 1'b1;
               end
            end
            LOAD: if (div_last) begin
               if (idx == 3'd0) begin
                  shadow_din <= load_din;
                  shadow_dp  <= load_dp;
               end
               ds      <= word[WORD_BITS-1];
               shreg   <= word << 1;
               bit_cnt <= '0;
               state   <= SHIFT_LO;
            end
            SHIFT_LO: if (div_last) begin
               sh_clk <= 1'b1;
               state  <= SHIFT_HI;
            end
            SHIFT_HI: if (div_last) begin
               sh_clk <= 1'b0;
               if (bit_cnt == 4'(WORD_BITS - 1)) begin
                  st_clk <= 1'b1;
                  state  <= LATCH;
               end else begin
                  ds      <= shreg[WORD_BITS-1];
                  shreg   <= shreg << 1;
                  bit_cnt <= bit_cnt + 1'b1;
                  state   <= SHIFT_LO;
               end
            end
            LATCH: if (div_last) begin
               st_clk <= 1'b0;
               busy   <= 1'b0;
               state  <= IDLE;
               if (idx == 3'(DIGITS - 1)) begin
                  idx        <= '0;
                  frame_done <= 1'b1;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hc595_scan_driver.sv
// Scoreboard bench for hc595_scan_driver (DIGITS=6, CLK_DIV=2, SCAN_CYC=100).
module tb_hc595_scan_driver;

   localparam int unsigned ND  = 6;
   localparam int unsigned SLT = 100;

   logic          sys_clk = 1'b0;
   logic          rst_n   = 1'b0;
   logic [23:0]   din     = '0;
   logic [5:0]    dp      = '0;
   logic          upd     = 1'b0;
   logic          en      = 1'b1;
   logic          ds, sh_clk, st_clk, busy, frame_done;

   hc595_scan_driver #(
      .DIGITS         (ND),
      .CLK_DIV        (2),
      .SCAN_CYC       (SLT),
      .SEG_ACTIVE_LOW (1'b1)
   ) dut (
      .sys_clk    (sys_clk),
      .rst_n      (rst_n),
      .din        (din),
      .dp         (dp),
      .upd        (upd),
      .en         (en),
      .ds         (ds),
      .sh_clk     (sh_clk),
      .st_clk     (st_clk),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct packed {
      logic [15:0] word;
      logic        last;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   fd_seen = 0;
   int   fd_exp  = 0;
   logic pend_fd = 1'b0;

   // Cycles since reset release, counted by the bench itself.
   int unsigned cyc = 0;
   always @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // Reference model state.
   logic [23:0] m_pend_d = '0, m_shad_d = '0;
   logic [5:0]  m_pend_p = '0, m_shad_p = '0;
   int unsigned m_idx = 0;
   int unsigned slot  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   function automatic logic [15:0] model_word(input logic [23:0] d, input logic [5:0] p,
                                              input logic e, input int unsigned k);
      logic [3:0] n;
      logic       lit;
      logic [7:0] s;
      logic [7:0] one;
      n   = 4'((d >> (4 * k)) & 24'hF);
      lit = e;
`ifdef HC595_LZ_BLANK_EN
      if (k != 0 && !p[k] && (d >> (4 * k)) == 24'h0) lit = 1'b0;
`endif
      s   = lit ? {p[k], tbl[n]} : 8'h00;
      one = 8'h01;
      return {~s, ~(one << k)};
   endfunction

   task automatic wait_cyc(input int unsigned c);
      while (cyc < c) @(negedge sys_clk);
   endtask

   // One digit slot: set inputs in the idle gap, push the expected word.
   task automatic do_slot(input logic e, input logic do_upd, input logic [23:0] d,
                          input logic [5:0] p, input logic in_load);
      exp_t x;
      wait_cyc(slot * SLT + 85);
      en = e;
      if (do_upd) begin
         din = d;
         dp  = p;
         m_pend_d = d;
         m_pend_p = p;
         if (!in_load) begin
            upd = 1'b1;
            @(negedge sys_clk);
            upd = 1'b0;
         end
      end
      if (m_idx == 0) begin
         m_shad_d = m_pend_d;
         m_shad_p = m_pend_p;
      end
      x.word = model_word(m_shad_d, m_shad_p, e, m_idx);
      x.last = (m_idx == ND - 1);
      if (x.last) fd_exp++;
      exp_q.push_back(x);
      m_idx = (m_idx + 1) % ND;
      if (do_upd && in_load) begin
         wait_cyc(slot * SLT + 100);
         upd = 1'b1;
         @(negedge sys_clk);
         upd = 1'b0;
      end
      slot++;
   endtask

   // Monitor: assemble shifted bits, compare at each latch, track frame_done.
   initial begin
      logic [15:0] cap = '0;
      int          nsh = 0;
      logic        prev_sh = 1'b0, prev_st = 1'b0;
      exp_t        e;
      forever begin
         @(negedge sys_clk);
         if (!rst_n) begin
            cap = '0; nsh = 0; prev_sh = 1'b0; prev_st = 1'b0; pend_fd = 1'b0;
         end else begin
            if (sh_clk && !prev_sh) begin
               cap = {cap[14:0], ds};
               nsh++;
            end
            if (st_clk && !prev_st) begin
               if (exp_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL latch_unexpected: got word %0h expected no latch", cap);
               end else begin
                  e = exp_q.pop_front();
                  check("word", 32'(cap), 32'(e.word));
                  check("sh_edges", 32'(nsh), 32'd16);
                  check("busy_at_latch", 32'(busy), 32'd1);
                  if (pend_fd) begin
                     total++; bad++;
                     $display("FAIL frame_done_missing: got 0 expected 1");
                  end
                  pend_fd = e.last;
               end
               nsh = 0;
            end
            if (frame_done) begin
               check("frame_done_expected", 32'(pend_fd), 32'd1);
               fd_seen++;
               pend_fd = 1'b0;
            end
            prev_sh = sh_clk;
            prev_st = st_clk;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0] outs;
      repeat (3) @(negedge sys_clk);
      outs = {ds, sh_clk, st_clk, busy, frame_done};
      check("reset_outputs", 32'(outs), 32'd0);
      rst_n = 1'b1;

      // Frame 1: 0x123456, digit 0 word {~7D, FE}.
      do_slot(1'b1, 1'b1, 24'h123456, 6'h00, 1'b0);
      repeat (5) do_slot(1'b1, 1'b0, '0, '0, 1'b0);
      // Frame 2: zero data strobed at idx 3 must not tear the frame.
      repeat (3) do_slot(1'b1, 1'b0, '0, '0, 1'b0);
      do_slot(1'b1, 1'b1, 24'h000000, 6'h00, 1'b0);
      repeat (2) do_slot(1'b1, 1'b0, '0, '0, 1'b0);
      // Frame 3: new data appears; display disabled.
      repeat (6) do_slot(1'b0, 1'b0, '0, '0, 1'b0);
      // Frame 4: strobe coinciding with LOAD at idx 0.
      do_slot(1'b1, 1'b1, 24'hABCDEF, 6'h2A, 1'b1);
      repeat (5) do_slot(1'b1, 1'b0, '0, '0, 1'b0);
      // Frame 5: leading-zero case.
      do_slot(1'b1, 1'b1, 24'h000042, 6'h00, 1'b0);
      repeat (5) do_slot(1'b1, 1'b0, '0, '0, 1'b0);
      // Reset during SHIFT_HI of bit 7 of the idx 2 slot.
      repeat (2) do_slot(1'b1, 1'b0, '0, '0, 1'b0);
      do_slot(1'b1, 1'b0, '0, '0, 1'b0);
      wait_cyc((slot - 1) * SLT + 100 + 32);
      rst_n = 1'b0;
      #1;
      outs = {ds, sh_clk, st_clk, busy, frame_done};
      check("async_reset_outputs", 32'(outs), 32'd0);
      void'(exp_q.pop_back());
      if (m_idx == 0) fd_exp--;
      m_idx = 0; slot = 0;
      m_pend_d = '0; m_pend_p = '0; m_shad_d = '0; m_shad_p = '0;
      repeat (3) @(negedge sys_clk);
      rst_n = 1'b1;

      // Randomized frames after reset.
      for (int i = 0; i < 24; i++) begin
         logic        e, u, l;
         logic [23:0] d;
         logic [5:0]  p;
         e = ($urandom_range(3) != 0);
         u = ($urandom_range(2) == 0) || (i == 0);
         d = 24'($urandom);
         p = 6'($urandom);
         l = u && ($urandom_range(1) == 1);
         do_slot(e, u, d, p, l);
      end

      wait_cyc(slot * SLT + 85);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("frame_done_count", 32'(fd_seen), 32'(fd_exp));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
